// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory write arbiter.
//   - default parameter constants
//   - global arbiter FSM state encoding
//   - per-core status encoding reported back to each processor
package dm_arb_pkg;

  localparam int DEF_NUM_CORES  = 4;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_RUN   = 2'b01,
    ARB_DRAIN = 2'b10,
    ARB_DONE  = 2'b11
  } arb_state_e;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'b00,
    CS_RUN   = 2'b01,
    CS_STALL = 2'b10,
    CS_DONE  = 2'b11
  } core_status_e;

endpackage

// File: rtl/wr_fifo.sv
// Per-core write buffer: small synchronous FIFO with show-ahead read.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clock, rst_r_n  clock / async active-low reset (empties the buffer)
//   push, wdata     write one entry (ignored when full)
//   pop             retire the head entry (ignored when empty)
//   rdata           head entry, valid whenever empty is low
//   full, empty     occupancy flags
module wr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             rst_r_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] store [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = store[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or negedge rst_r_n) begin
    if (!rst_r_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Entry storage needs no reset: it is only observed while non-empty.
  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/dm_write_arbiter.sv
// Shares one data-memory write port between NUM_CORES processor cores.
// Each core writes into its own buffer; a round-robin arbiter drains one
// buffer entry per cycle into a registered memory write port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | waiting for start; all core requests dropped
// ARB_RUN   | cores write into their buffers, arbiter drains them
// ARB_DRAIN | every core has ended; remaining entries still being written
// ARB_DONE  | all buffers empty; all_done high until the next start
//
// Ports:
//   clock, rst_r_n        clock / async active-low reset
//   start                 one-cycle pulse: IDLE->RUN, DONE->IDLE
//   core_dm_en            per-core write request
//   core_ar, core_wdata   per-core address / data, core i at slice i
//   core_end              per-core end_process
//   core_status           per-core 2-bit status, core i at [2i+1:2i]
//   mem_we/addr/wdata     shared memory write port (addr/data hold when idle)
//   all_done              registered, high only in ARB_DONE
module dm_write_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clock,
  input  logic                        rst_r_n,
  input  logic                        start,
  input  logic [NUM_CORES-1:0]        core_dm_en,
  input  logic [NUM_CORES*ADDR_W-1:0] core_ar,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_end,
  output logic [2*NUM_CORES-1:0]      core_status,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        all_done
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int IDX_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  arb_state_e           state;
  arb_state_e           state_next;
  logic [NUM_CORES-1:0] fifo_full;
  logic [NUM_CORES-1:0] fifo_empty;
  logic [NUM_CORES-1:0] fifo_push;
  logic [NUM_CORES-1:0] fifo_pop;
  logic [ENTRY_W-1:0]   fifo_rdata [NUM_CORES];
  logic [ENTRY_W-1:0]   grant_entry;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand_idx;
  logic                 grant_valid;
  logic                 all_end;
  logic                 all_empty;
  int                   cand;

  assign all_end   = &core_end;
  assign all_empty = &fifo_empty;

  always_ff @(posedge clock or negedge rst_r_n) begin
    if (!rst_r_n) state <= ARB_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE:  if (start)     state_next = ARB_RUN;
      ARB_RUN:   if (all_end)   state_next = ARB_DRAIN;
      ARB_DRAIN: if (all_empty) state_next = ARB_DONE;
      ARB_DONE:  if (start)     state_next = ARB_IDLE;
      default:                  state_next = ARB_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    core_status_e cs;

    // Status is combinational from buffer occupancy so a core sees STALL in
    // the very cycle its buffer fills, even if that buffer pops this cycle.
    always_comb begin
      cs = CS_IDLE;
      unique case (state)
        ARB_RUN, ARB_DRAIN: begin
          if (fifo_full[i])                       cs = CS_STALL;
          else if (core_end[i] && fifo_empty[i])  cs = CS_DONE;
          else                                    cs = CS_RUN;
        end
        ARB_DONE: cs = CS_DONE;
        default:  cs = CS_IDLE;
      endcase
    end

    assign core_status[2*i +: 2] = cs;
    assign fifo_push[i] = core_dm_en[i] && (cs == CS_RUN);
    assign fifo_pop[i]  = grant_valid && (grant_idx == IDX_W'(i));

    wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clock   (clock),
      .rst_r_n (rst_r_n),
      .push    (fifo_push[i]),
      .wdata   ({core_ar[i*ADDR_W +: ADDR_W], core_wdata[i*DATA_W +: DATA_W]}),
      .pop     (fifo_pop[i]),
      .rdata   (fifo_rdata[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );
  end

  // Round-robin: search starts at rr_ptr, which points one past the last
  // granted core.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand        = 0;
    cand_idx    = '0;
    if (state == ARB_RUN || state == ARB_DRAIN) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        cand     = (int'(rr_ptr) + k) % NUM_CORES;
        cand_idx = IDX_W'(cand);
        if (!grant_valid && !fifo_empty[cand_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  assign grant_entry = fifo_rdata[grant_idx];

  always_ff @(posedge clock or negedge rst_r_n) begin
    if (!rst_r_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_ptr    <= '0;
      all_done  <= 1'b0;
    end else begin
      mem_we <= grant_valid;
      if (grant_valid) begin
        mem_addr  <= grant_entry[ENTRY_W-1 -: ADDR_W];
        mem_wdata <= grant_entry[DATA_W-1:0];
        rr_ptr    <= (grant_idx == IDX_W'(NUM_CORES-1)) ? '0 : grant_idx + IDX_W'(1);
      end
      all_done <= (state_next == ARB_DONE);
    end
  end

endmodule

// File: tb/tb_dm_write_arbiter.sv
// Directed, table-driven bench for dm_write_arbiter (default parameters).
// Each vector drives inputs on a falling edge, lets one rising edge pass and
// checks outputs on the next falling edge. Expected memory writes are named
// by (core, step it was pushed); address/data come from mk_addr/mk_data.
module tb_dm_write_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic            clock = 1'b0;
  logic            rst_r_n = 1'b0;
  logic            start = 1'b0;
  logic [NC-1:0]   core_dm_en = '0;
  logic [NC*AW-1:0] core_ar = '0;
  logic [NC*DW-1:0] core_wdata = '0;
  logic [NC-1:0]   core_end = '0;
  logic [2*NC-1:0] core_status;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            all_done;

  always #5 clock = ~clock;

  dm_write_arbiter dut (
    .clock       (clock),
    .rst_r_n     (rst_r_n),
    .start       (start),
    .core_dm_en  (core_dm_en),
    .core_ar     (core_ar),
    .core_wdata  (core_wdata),
    .core_end    (core_end),
    .core_status (core_status),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .all_done    (all_done)
  );

  typedef struct {
    logic       start;
    logic [3:0] en;
    logic [3:0] endv;
    int         step;
    logic       exp_we;
    int         exp_core;
    int         exp_step;
    logic [7:0] exp_status;
    logic       exp_done;
  } vec_t;

  vec_t          vecs[$];
  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] exp_addr_q = '0;
  logic [DW-1:0] exp_data_q = '0;

  function automatic logic [AW-1:0] mk_addr(int core, int s);
    if (core == 0 && s == 6) return 16'h0010;
    return 16'(32'h1000 * (core + 1) + s);
  endfunction

  function automatic logic [DW-1:0] mk_data(int core, int s);
    if (core == 0 && s == 6) return 8'hA5;
    return 8'(core * 64 + s);
  endfunction

  function automatic vec_t mkv(logic st, logic [3:0] en, logic [3:0] ev, int s,
                               logic we, int core, int es, logic [7:0] stat, logic done);
    vec_t v;
    v.start = st; v.en = en; v.endv = ev; v.step = s;
    v.exp_we = we; v.exp_core = core; v.exp_step = es;
    v.exp_status = stat; v.exp_done = done;
    return v;
  endfunction

  function automatic void add(logic st, logic [3:0] en, logic [3:0] ev, logic we,
                              int core, int es, logic [7:0] stat, logic done);
    vecs.push_back(mkv(st, en, ev, vecs.size(), we, core, es, stat, done));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_step(vec_t v);
    start      = v.start;
    core_dm_en = v.en;
    core_end   = v.endv;
    for (int i = 0; i < NC; i++) begin
      core_ar[i*AW +: AW]    = mk_addr(i, v.step);
      core_wdata[i*DW +: DW] = mk_data(i, v.step);
    end
    @(posedge clock);
    @(negedge clock);
    if (v.exp_we) begin
      exp_addr_q = mk_addr(v.exp_core, v.exp_step);
      exp_data_q = mk_data(v.exp_core, v.exp_step);
    end
    check($sformatf("s%0d mem_we", v.step),      32'(mem_we),      32'(v.exp_we));
    check($sformatf("s%0d mem_addr", v.step),    32'(mem_addr),    32'(exp_addr_q));
    check($sformatf("s%0d mem_wdata", v.step),   32'(mem_wdata),   32'(exp_data_q));
    check($sformatf("s%0d core_status", v.step), 32'(core_status), 32'(v.exp_status));
    check($sformatf("s%0d all_done", v.step),    32'(all_done),    32'(v.exp_done));
  endtask

  task automatic check_zero(string tag);
    check({tag, " mem_we"},      32'(mem_we),      32'd0);
    check({tag, " mem_addr"},    32'(mem_addr),    32'd0);
    check({tag, " mem_wdata"},   32'(mem_wdata),   32'd0);
    check({tag, " core_status"}, 32'(core_status), 32'd0);
    check({tag, " all_done"},    32'(all_done),    32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_zero("reset");
    rst_r_n = 1'b1;

    //  st  en       end      we core step status done
    add(1, 4'b0000, 4'b0000, 0, 0, 0,  8'h55, 0);  // 0  IDLE->RUN
    add(0, 4'b1111, 4'b0000, 0, 0, 0,  8'h55, 0);  // 1  all cores write
    add(0, 4'b0000, 4'b0000, 1, 0, 1,  8'h55, 0);  // 2  core0 first
    add(0, 4'b0000, 4'b0000, 1, 1, 1,  8'h55, 0);  // 3
    add(0, 4'b0000, 4'b0000, 1, 2, 1,  8'h55, 0);  // 4
    add(0, 4'b0000, 4'b0000, 1, 3, 1,  8'h55, 0);  // 5
    add(0, 4'b0001, 4'b0000, 0, 0, 0,  8'h55, 0);  // 6  core0 0x0010/0xA5
    add(0, 4'b0000, 4'b0000, 1, 0, 6,  8'h55, 0);  // 7  two cycles later
    add(0, 4'b0000, 4'b0000, 0, 0, 0,  8'h55, 0);  // 8  addr/data hold
    add(0, 4'b0011, 4'b0000, 0, 0, 0,  8'h55, 0);  // 9  pointer at core1
    add(0, 4'b0000, 4'b0000, 1, 1, 9,  8'h55, 0);  // 10 core1 before core0
    add(0, 4'b0000, 4'b0000, 1, 0, 9,  8'h55, 0);  // 11
    add(0, 4'b0000, 4'b0000, 0, 0, 0,  8'h55, 0);  // 12
    add(0, 4'b1101, 4'b0000, 0, 0, 0,  8'h55, 0);  // 13 cores 0,2,3 flood
    add(0, 4'b1111, 4'b0000, 1, 2, 13, 8'h96, 0);  // 14 core1 write 1
    add(0, 4'b1111, 4'b0000, 1, 3, 13, 8'h6A, 0);  // 15 core1 write 2 -> full
    add(0, 4'b1111, 4'b0000, 1, 0, 13, 8'hA9, 0);  // 16 core1 write 3 dropped
    add(0, 4'b0000, 4'b0000, 1, 1, 14, 8'hA5, 0);  // 17
    add(0, 4'b0000, 4'b0000, 1, 2, 14, 8'h95, 0);  // 18
    add(0, 4'b0000, 4'b0000, 1, 3, 14, 8'h55, 0);  // 19
    add(0, 4'b0000, 4'b0000, 1, 0, 14, 8'h55, 0);  // 20
    add(0, 4'b0000, 4'b0000, 1, 1, 15, 8'h55, 0);  // 21
    add(0, 4'b0000, 4'b0000, 1, 2, 15, 8'h55, 0);  // 22
    add(0, 4'b0000, 4'b0000, 1, 3, 16, 8'h55, 0);  // 23
    add(0, 4'b0000, 4'b0000, 0, 0, 0,  8'h55, 0);  // 24 nothing of core1 step 16
    add(0, 4'b0101, 4'b0000, 0, 0, 0,  8'h55, 0);  // 25 two entries pending
    add(0, 4'b0000, 4'b1111, 1, 0, 25, 8'hDF, 0);  // 26 RUN->DRAIN
    add(0, 4'b0000, 4'b1111, 1, 2, 25, 8'hFF, 0);  // 27
    add(0, 4'b0000, 4'b1111, 0, 0, 0,  8'hFF, 1);  // 28 DONE
    add(0, 4'b0000, 4'b0000, 0, 0, 0,  8'hFF, 1);  // 29 DONE holds
    add(1, 4'b0000, 4'b0000, 0, 0, 0,  8'h00, 0);  // 30 DONE->IDLE
    add(1, 4'b0000, 4'b0000, 0, 0, 0,  8'h55, 0);  // 31 IDLE->RUN
    add(0, 4'b0011, 4'b0000, 0, 0, 0,  8'h55, 0);  // 32
    add(1, 4'b0000, 4'b0000, 1, 0, 32, 8'h55, 0);  // 33 start in RUN ignored
    add(0, 4'b0000, 4'b0000, 1, 1, 32, 8'h55, 0);  // 34
    add(0, 4'b0000, 4'b0000, 0, 0, 0,  8'h55, 0);  // 35
    add(0, 4'b1111, 4'b0000, 0, 0, 0,  8'h55, 0);  // 36 fill buffers
    add(0, 4'b0000, 4'b0000, 1, 2, 36, 8'h55, 0);  // 37 three entries remain

    foreach (vecs[n]) run_step(vecs[n]);

    // Reset mid-run with three buffered entries.
    #2 rst_r_n = 1'b0;
    #1 check_zero("midreset");
    exp_addr_q = '0;
    exp_data_q = '0;
    start      = 1'b0;
    core_dm_en = '0;
    core_end   = '0;
    @(negedge clock);
    @(negedge clock);
    rst_r_n = 1'b1;

    // Requests while IDLE after reset must be dropped; no stale writes.
    for (int i = 0; i < 4; i++)
      run_step(mkv(0, 4'b1111, 4'b0000, 40 + i, 0, 0, 0, 8'h00, 0));
    run_step(mkv(1, 4'b0000, 4'b0000, 44, 0, 0, 0, 8'h55, 0));
    run_step(mkv(0, 4'b0000, 4'b0000, 45, 0, 0, 0, 8'h55, 0));
    // Round-robin pointer back at core0: core0 wins over core3.
    run_step(mkv(0, 4'b1001, 4'b0000, 50, 0, 0, 0,  8'h55, 0));
    run_step(mkv(0, 4'b0000, 4'b0000, 51, 1, 0, 50, 8'h55, 0));
    run_step(mkv(0, 4'b0000, 4'b0000, 52, 1, 3, 50, 8'h55, 0));
    run_step(mkv(0, 4'b0000, 4'b0000, 53, 0, 0, 0,  8'h55, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
